// File: rtl/corr_iter_sched.sv
// rtl/corr_iter_sched.sv - iterative evaluator for the IO_PAIRS x DEPTH 2-bit primitive lattice
//
// Purpose: holds one W-bit lattice vector and applies one stage of lane
// primitives per clock, DEPTH times per job, instead of unrolling DEPTH stages.
// Jobs arrive and results leave over valid/ready handshakes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   abort      (only with CORR_SCHED_ABORT_EN) drop the current job, back to IDLE
//   in_valid   job offered
//   in_ready   block can accept a job (IDLE)
//   in_data    initial lattice vector, sampled on the accept edge only
//   out_valid  result available (DONE)
//   out_ready  consumer takes the result
//   out_data   lattice vector after DEPTH stages (mirrors the working vector)
//   busy       high while stages are being applied
//   iter       index of the stage being applied, 0 outside RUN
//   jobs_done  count of result handshakes, wraps at 16 bits
//
// Optional feature macro: CORR_SCHED_ABORT_EN (adds the abort input).

module corr_iter_sched #(
  parameter  int IO_PAIRS = 4,
  parameter  int DEPTH    = 8,
  localparam int W        = 2 * IO_PAIRS,
  localparam int IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef CORR_SCHED_ABORT_EN
  input  logic          abort,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          busy,
  output logic [IW-1:0] iter,
  output logic [15:0]   jobs_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  localparam logic [IW-1:0] LAST_ITER = IW'(DEPTH - 1);

  stateT        state;
  logic [W-1:0] vec;
  logic         abortReq;

`ifdef CORR_SCHED_ABORT_EN
  assign abortReq = abort;
`else
  assign abortReq = 1'b0;
`endif

  // One lattice stage: every 2-bit lane counts up by one (mod 4).
  function automatic logic [W-1:0] applyStage(input logic [W-1:0] v);
    logic [W-1:0] o;
    o = '0;
    for (int j = 0; j < IO_PAIRS; j++) begin
      o[2*j+1] = v[2*j+1] ^ v[2*j];
      o[2*j]   = ~v[2*j];
    end
    return o;
  endfunction

  assign out_data = vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= '0;
      iter      <= '0;
      jobs_done <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else if (abortReq && (state != IDLE)) begin
      // Abort wins over both stage completion and a pending result handshake.
      state     <= IDLE;
      iter      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is 1 throughout IDLE, so in_valid alone completes the handshake.
          if (in_valid) begin
            vec      <= in_data;
            iter     <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          vec <= applyStage(vec);
          if (iter == LAST_ITER) begin
            state     <= DONE;
            iter      <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            iter <= iter + IW'(1);
          end
        end
        DONE: begin
          // in_valid is ignored here; acceptance reopens the cycle after the result handshake.
          if (out_ready) begin
            jobs_done <= jobs_done + 16'd1;
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          iter      <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_corr_iter_sched.sv
// tb/tb_corr_iter_sched.sv - scoreboard bench for corr_iter_sched at DEPTH 8, 3 and 1

module tb_corr_iter_sched;

  localparam int N = 3;
  localparam int DEP [N] = '{8, 3, 1};

  typedef struct {
    logic [7:0] data;
    int         acc;
  } expT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rstN     [N];
  logic        inValid  [N];
  logic        inReady  [N];
  logic [7:0]  inData   [N];
  logic        outValid [N];
  logic        outReady [N];
  logic [7:0]  outData  [N];
  logic        busy     [N];
  logic        abortIn  [N];
  logic [2:0]  iterW    [N];
  logic [15:0] jobsDone [N];

  logic [2:0] iter0;
  logic [1:0] iter1;
  logic [0:0] iter2;
  assign iterW[0] = iter0;
  assign iterW[1] = {1'b0, iter1};
  assign iterW[2] = {2'b00, iter2};

  corr_iter_sched #(.IO_PAIRS(4), .DEPTH(8)) dut0 (
    .clk(clk), .rst_n(rstN[0]),
`ifdef CORR_SCHED_ABORT_EN
    .abort(abortIn[0]),
`endif
    .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]),
    .busy(busy[0]), .iter(iter0), .jobs_done(jobsDone[0])
  );

  corr_iter_sched #(.IO_PAIRS(4), .DEPTH(3)) dut1 (
    .clk(clk), .rst_n(rstN[1]),
`ifdef CORR_SCHED_ABORT_EN
    .abort(abortIn[1]),
`endif
    .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]),
    .busy(busy[1]), .iter(iter1), .jobs_done(jobsDone[1])
  );

  corr_iter_sched #(.IO_PAIRS(4), .DEPTH(1)) dut2 (
    .clk(clk), .rst_n(rstN[2]),
`ifdef CORR_SCHED_ABORT_EN
    .abort(abortIn[2]),
`endif
    .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2]),
    .out_valid(outValid[2]), .out_ready(outReady[2]), .out_data(outData[2]),
    .busy(busy[2]), .iter(iter2), .jobs_done(jobsDone[2])
  );

  int  total = 0;
  int  bad   = 0;
  expT expQ      [N][$];
  int  modelDone [N];

  task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s dut%0d got=%0h want=%0h cyc=%0d", name, k, got, want, cyc);
    end
  endtask

  // Reference: every lane advances by DEPTH modulo 4.
  function automatic logic [7:0] golden(input logic [7:0] d, input int depth);
    logic [7:0] r;
    int lane;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      lane = int'(d[2*j +: 2]);
      r[2*j +: 2] = 2'((lane + depth) % 4);
    end
    return r;
  endfunction

  // Monitor: the outputs follow from the cycle distance to the pending job's accept edge.
  always @(negedge clk) begin
    int rel;
    for (int k = 0; k < N; k++) begin
      check("jobs_done", k, 32'(jobsDone[k]), 32'(modelDone[k] & 32'hFFFF));
      if (expQ[k].size() == 0) rel = -1;
      else rel = cyc - expQ[k][0].acc;
      if (rel < 0) begin
        check("idle_busy", k, 32'(busy[k]), 0);
        check("idle_out_valid", k, 32'(outValid[k]), 0);
        check("idle_iter", k, 32'(iterW[k]), 0);
        check("idle_in_ready", k, 32'(inReady[k]), 1);
      end else if (rel < DEP[k]) begin
        check("run_busy", k, 32'(busy[k]), 1);
        check("run_iter", k, 32'(iterW[k]), rel);
        check("run_out_valid", k, 32'(outValid[k]), 0);
        check("run_in_ready", k, 32'(inReady[k]), 0);
      end else begin
        check("done_out_valid", k, 32'(outValid[k]), 1);
        check("done_busy", k, 32'(busy[k]), 0);
        check("done_iter", k, 32'(iterW[k]), 0);
        check("done_in_ready", k, 32'(inReady[k]), 0);
        check("out_data", k, 32'(outData[k]), 32'(expQ[k][0].data));
        if (outReady[k] && !abortIn[k]) begin
          void'(expQ[k].pop_front());
          modelDone[k]++;
        end
      end
    end
  end

  // Called just after a rising edge; returns once the accept edge has passed.
  task automatic sendJob(input int k, input logic [7:0] d, output int acc);
    int  n;
    expT e;
    n = 0;
    inValid[k] = 1'b1;
    inData[k]  = d;
    while (!inReady[k] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!inReady[k]) begin
      check("accept_timeout", k, 32'(inReady[k]), 1);
      inValid[k] = 1'b0;
      acc = -1;
      return;
    end
    acc    = cyc + 1;
    e.data = golden(d, DEP[k]);
    e.acc  = acc;
    expQ[k].push_back(e);
    @(posedge clk); #1;
    inValid[k] = 1'b0;
  endtask

  task automatic waitDone(input int k);
    int n;
    n = 0;
    while (expQ[k].size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_timeout", k, 32'(expQ[k].size()), 0);
  endtask

  task automatic waitIter(input int k, input int want);
    int n;
    n = 0;
    while (int'(iterW[k]) != want && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("iter_reach", k, 32'(iterW[k]), want);
  endtask

  task automatic randomJobs(input int k, input int count);
    int acc;
    int n;
    repeat (count) begin
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      sendJob(k, 8'($urandom), acc);
      n = 0;
      while (expQ[k].size() != 0 && n < 300) begin
        outReady[k] = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        n++;
      end
      outReady[k] = 1'b1;
      waitDone(k);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rstN[k]      = 1'b1;
      inValid[k]   = 1'b0;
      inData[k]    = '0;
      outReady[k]  = 1'b1;
      abortIn[k]   = 1'b0;
      modelDone[k] = 0;
    end
    #1;
    for (int k = 0; k < N; k++) rstN[k] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) rstN[k] = 1'b1;

    fork
      begin : lane0
        int a;
        sendJob(0, 8'hE4, a);
        waitDone(0);
        check("first_jobs_done", 0, 32'(jobsDone[0]), 1);
        // Asynchronous reset in the middle of a run.
        sendJob(0, 8'($urandom), a);
        waitIter(0, 4);
        rstN[0] = 1'b0;
        expQ[0].delete();
        modelDone[0] = 0;
        #1;
        check("rst_busy", 0, 32'(busy[0]), 0);
        check("rst_out_valid", 0, 32'(outValid[0]), 0);
        check("rst_iter", 0, 32'(iterW[0]), 0);
        check("rst_in_ready", 0, 32'(inReady[0]), 1);
        check("rst_jobs_done", 0, 32'(jobsDone[0]), 0);
        @(posedge clk); #1;
        rstN[0] = 1'b1;
        sendJob(0, 8'h5A, a);
        waitDone(0);
`ifdef CORR_SCHED_ABORT_EN
        // Abort during RUN.
        sendJob(0, 8'h3C, a);
        waitIter(0, 2);
        abortIn[0] = 1'b1;
        @(posedge clk); #1;
        abortIn[0] = 1'b0;
        void'(expQ[0].pop_front());
        // Abort held in IDLE must not block acceptance.
        abortIn[0] = 1'b1;
        sendJob(0, 8'hC3, a);
        abortIn[0] = 1'b0;
        waitDone(0);
        // Abort in DONE beats a simultaneous out_ready.
        outReady[0] = 1'b0;
        sendJob(0, 8'h96, a);
        repeat (DEP[0] + 1) begin @(posedge clk); #1; end
        check("abort_done_ov", 0, 32'(outValid[0]), 1);
        abortIn[0]  = 1'b1;
        outReady[0] = 1'b1;
        @(posedge clk); #1;
        abortIn[0] = 1'b0;
        void'(expQ[0].pop_front());
        sendJob(0, 8'h69, a);
        waitDone(0);
`endif
        randomJobs(0, 15);
      end
      begin : lane1
        int a;
        int n;
        // Result held back for 5 cycles while in_valid pulses are offered.
        outReady[1] = 1'b0;
        sendJob(1, 8'hE4, a);
        n = 0;
        while (!outValid[1] && n < 50) begin @(posedge clk); #1; n++; end
        check("hold_out_valid", 1, 32'(outValid[1]), 1);
        repeat (5) begin
          inValid[1] = ~inValid[1];
          inData[1]  = 8'($urandom);
          @(posedge clk); #1;
        end
        // Release with in_valid also high: only the result handshake may happen.
        outReady[1] = 1'b1;
        sendJob(1, 8'h00, a);
        waitDone(1);
        randomJobs(1, 25);
      end
      begin : lane2
        int a;
        int first;
        sendJob(2, 8'h1B, first);
        a = first;
        repeat (99) sendJob(2, 8'($urandom), a);
        waitDone(2);
        check("b2b_spacing", 2, 32'(a - first), 99 * 3);
        check("b2b_jobs_done", 2, 32'(jobsDone[2]), 100);
        randomJobs(2, 25);
      end
    join

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
